// File: rtl/gpu_ucode_sequencer_pkg.sv
// Shared GPU microcode definitions: opcode values, uop field positions,
// sequencer state encodings and the zero-flag update classifier.
package gpu_ucode_sequencer_pkg;

  localparam logic [4:0] GNOP   = 5'd0;
  localparam logic [4:0] GWRL   = 5'd1;
  localparam logic [4:0] GWRR   = 5'd2;
  localparam logic [4:0] GADD   = 5'd3;
  localparam logic [4:0] GADDL  = 5'd4;
  localparam logic [4:0] GSUB   = 5'd5;
  localparam logic [4:0] GSUBL  = 5'd6;
  localparam logic [4:0] GAND   = 5'd7;
  localparam logic [4:0] GRVMEM = 5'd8;
  localparam logic [4:0] GWBG   = 5'd9;
  localparam logic [4:0] GJZ    = 5'd10;
  localparam logic [4:0] GJNZ   = 5'd11;
  localparam logic [4:0] GGOTO  = 5'd12;

  localparam int OP_LSB   = 15;
  localparam int DEST_LSB = 10;
  localparam int SRC1_LSB = 5;
  localparam int SRC0_LSB = 0;
  localparam int FIELD_W  = 5;
  localparam int LIT_W    = 10;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RUN       = 2'd1,
    S_VMEM_WAIT = 2'd2,
    S_FB_WAIT   = 2'd3
  } seq_state_e;

  function automatic logic updates_zero(input logic [4:0] op);
    logic hit;
    case (op)
      GADD, GADDL, GSUB, GSUBL, GAND: hit = 1'b1;
      default:                        hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/gpu_next_pc.sv
// Branch resolution for the micro-PC: picks the jump target or the
// sequential successor for a retiring uop, and holds the PC otherwise.
module gpu_next_pc
  import gpu_ucode_sequencer_pkg::*;
#(
  parameter int PC_WIDTH = 8
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [4:0]          op,
  input  logic [PC_WIDTH-1:0] target,
  input  logic                zero,
  input  logic                retire,
  output logic [PC_WIDTH-1:0] next_pc
);

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  logic [PC_WIDTH-1:0] seq_pc_s;

  // Sequential successor wraps naturally at 2^PC_WIDTH.
  always_comb begin
    seq_pc_s = pc + PC_ONE;
    next_pc  = pc;
    if (retire) begin
      case (op)
        GGOTO:   next_pc = target;
        GJZ:     next_pc = zero  ? target : seq_pc_s;
        GJNZ:    next_pc = !zero ? target : seq_pc_s;
        default: next_pc = seq_pc_s;
      endcase
    end else begin
      next_pc = pc;
    end
  end

endmodule

// File: rtl/gpu_ucode_sequencer.sv
// GPU microcode sequencer: owns the micro-PC, decodes the ROM uop into
// datapath fields, resolves branches and stalls on VRAM/framebuffer handshakes.
module gpu_ucode_sequencer
  import gpu_ucode_sequencer_pkg::*;
#(
  parameter int                     PC_WIDTH  = 8,
  parameter int                     UOP_WIDTH = 20,
  parameter logic [PC_WIDTH-1:0]    RESET_PC  = {PC_WIDTH{1'b0}}
) (
  input  logic                 iClock,
  input  logic                 iReset,
  input  logic                 iEnable,
  output logic [PC_WIDTH-1:0]  oUcodeAddr,
  input  logic [UOP_WIDTH-1:0] iUop,
  output logic [4:0]           oOp,
  output logic [4:0]           oDest,
  output logic [4:0]           oSrc1,
  output logic [4:0]           oSrc0,
  output logic [9:0]           oLiteral,
  output logic                 oExec,
  input  logic [15:0]          iAluResult,
  output logic                 oZero,
  output logic                 oVmemReq,
  input  logic                 iVmemAck,
  output logic                 oFbReq,
  input  logic                 iFbAck,
  output logic [1:0]           oState
);

  seq_state_e          state_r;
  seq_state_e          state_d;
  logic [PC_WIDTH-1:0] pc_r;
  logic [PC_WIDTH-1:0] pc_d;
  logic [PC_WIDTH-1:0] next_pc_s;
  logic                zero_r;
  logic                zero_d;
  logic                vmem_req_r;
  logic                fb_req_r;
  logic                exec_s;
  logic                go_idle_s;
  logic [4:0]          op_s;

  assign op_s     = iUop[OP_LSB +: FIELD_W];
  assign oOp      = op_s;
  assign oDest    = iUop[DEST_LSB +: FIELD_W];
  assign oSrc1    = iUop[SRC1_LSB +: FIELD_W];
  assign oSrc0    = iUop[SRC0_LSB +: FIELD_W];
  assign oLiteral = iUop[LIT_W-1:0];

  assign oUcodeAddr = pc_r;
  assign oExec      = exec_s;
  assign oZero      = zero_r;
  assign oVmemReq   = vmem_req_r;
  assign oFbReq     = fb_req_r;
  assign oState     = state_r;

  gpu_next_pc #(
    .PC_WIDTH (PC_WIDTH)
  ) u_next_pc (
    .pc      (pc_r),
    .op      (op_s),
    .target  (iUop[PC_WIDTH-1:0]),
    .zero    (zero_r),
    .retire  (exec_s),
    .next_pc (next_pc_s)
  );

  // FSM next state, retire qualifier and idle-return cleanup.
  // Retire is suppressed while reset is asserted so a late ack never leaks out.
  always_comb begin
    state_d   = state_r;
    exec_s    = 1'b0;
    go_idle_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (iEnable) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (!iEnable) begin
          state_d   = S_IDLE;
          go_idle_s = 1'b1;
        end else if (op_s == GRVMEM) begin
          state_d = S_VMEM_WAIT;
        end else if (op_s == GWBG) begin
          state_d = S_FB_WAIT;
        end else begin
          exec_s = !iReset;
        end
      end
      S_VMEM_WAIT: begin
        if (iVmemAck) begin
          exec_s    = !iReset;
          state_d   = iEnable ? S_RUN : S_IDLE;
          go_idle_s = !iEnable;
        end else begin
          state_d = S_VMEM_WAIT;
        end
      end
      S_FB_WAIT: begin
        if (iFbAck) begin
          exec_s    = !iReset;
          state_d   = iEnable ? S_RUN : S_IDLE;
          go_idle_s = !iEnable;
        end else begin
          state_d = S_FB_WAIT;
        end
      end
      default: begin
        state_d   = S_IDLE;
        go_idle_s = 1'b1;
      end
    endcase
  end

  // PC and zero-flag next values; returning to idle rewinds and clears.
  always_comb begin
    pc_d   = next_pc_s;
    zero_d = zero_r;
    if (go_idle_s) begin
      pc_d   = RESET_PC;
      zero_d = 1'b0;
    end else if (exec_s && updates_zero(op_s)) begin
      zero_d = (iAluResult == 16'h0000);
    end else begin
      zero_d = zero_r;
    end
  end

  // State, PC, flag and registered request lines.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_r    <= S_IDLE;
      pc_r       <= RESET_PC;
      zero_r     <= 1'b0;
      vmem_req_r <= 1'b0;
      fb_req_r   <= 1'b0;
    end else begin
      state_r    <= state_d;
      pc_r       <= pc_d;
      zero_r     <= zero_d;
      vmem_req_r <= (state_d == S_VMEM_WAIT);
      fb_req_r   <= (state_d == S_FB_WAIT);
    end
  end

endmodule

// File: tb/tb_gpu_ucode_sequencer.sv
// Directed self-checking bench for gpu_ucode_sequencer with a behavioural
// combinational ROM and hand-computed expectations.
module tb_gpu_ucode_sequencer;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [7:0]  addr;
  logic [19:0] uop;
  logic [4:0]  op, dest, src1, src0;
  logic [9:0]  literal;
  logic        exec;
  logic [15:0] alu;
  logic        zero;
  logic        vmem_req, vmem_ack;
  logic        fb_req, fb_ack;
  logic [1:0]  state;

  logic [19:0] rom [256];
  int          checks;
  int          errors;

  assign uop = rom[addr];

  gpu_ucode_sequencer #(
    .PC_WIDTH  (8),
    .UOP_WIDTH (20),
    .RESET_PC  (8'h00)
  ) dut (
    .iClock     (clk),
    .iReset     (rst),
    .iEnable    (enable),
    .oUcodeAddr (addr),
    .iUop       (uop),
    .oOp        (op),
    .oDest      (dest),
    .oSrc1      (src1),
    .oSrc0      (src0),
    .oLiteral   (literal),
    .oExec      (exec),
    .iAluResult (alu),
    .oZero      (zero),
    .oVmemReq   (vmem_req),
    .iVmemAck   (vmem_ack),
    .oFbReq     (fb_req),
    .iFbAck     (fb_ack),
    .oState     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Clear ROM to gnop, hold reset two edges, check reset values, release.
  task automatic do_reset();
    for (int i = 0; i < 256; i++) rom[i] = 20'h00000;
    rst      = 1'b1;
    enable   = 1'b0;
    vmem_ack = 1'b0;
    fb_ack   = 1'b0;
    alu      = 16'h0000;
    tick();
    tick();
    sample();
    check("rst_state", 32'(state), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_exec", 32'(exec), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_vreq", 32'(vmem_req), 32'd0);
    check("rst_freq", 32'(fb_req), 32'd0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; enable = 1'b0; vmem_ack = 1'b0; fb_ack = 1'b0; alu = 16'h0000;
    for (int i = 0; i < 256; i++) rom[i] = 20'h00000;

    // Sequential stepping and wrap over a gnop ROM.
    do_reset();
    enable = 1'b1;
    sample();
    check("idle_state", 32'(state), 32'd0);
    check("idle_exec", 32'(exec), 32'd0);
    tick();
    sample();
    check("run_state", 32'(state), 32'd1);
    check("run_exec", 32'(exec), 32'd1);
    check("step_addr0", 32'(addr), 32'd0);
    for (int i = 1; i < 4; i++) begin
      tick();
      sample();
      check("step_addr", 32'(addr), 32'(i));
    end
    repeat (252) tick();
    sample();
    check("addr_255", 32'(addr), 32'd255);
    tick();
    sample();
    check("addr_wrap", 32'(addr), 32'd0);

    // gsubl result zero, then gjnz not taken; then non-zero result, taken.
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      rom[20] = {5'd6, 5'd1, 5'd2, 5'd3};
      rom[21] = {5'd11, 5'd0, 10'h005};
      alu     = (pass == 0) ? 16'h0000 : 16'h0003;
      enable  = 1'b1;
      tick();
      repeat (20) tick();
      sample();
      check("br_addr20", 32'(addr), 32'd20);
      check("br_op", 32'(op), 32'd6);
      check("br_dest", 32'(dest), 32'd1);
      check("br_src1", 32'(src1), 32'd2);
      check("br_src0", 32'(src0), 32'd3);
      tick();
      sample();
      check("br_zero", 32'(zero), (pass == 0) ? 32'd1 : 32'd0);
      check("br_literal", 32'(literal), 32'h005);
      check("br_exec", 32'(exec), 32'd1);
      tick();
      sample();
      check("br_target", 32'(addr), (pass == 0) ? 32'd22 : 32'd5);
      check("br_state", 32'(state), 32'd1);
    end

    // VRAM read with ack three cycles after the request.
    do_reset();
    rom[6] = {5'd8, 15'h0000};
    enable = 1'b1;
    tick();
    repeat (6) tick();
    sample();
    check("vm_addr6", 32'(addr), 32'd6);
    check("vm_exec_issue", 32'(exec), 32'd0);
    check("vm_req_issue", 32'(vmem_req), 32'd0);
    tick();
    sample();
    check("vm_state", 32'(state), 32'd2);
    check("vm_req_c1", 32'(vmem_req), 32'd1);
    check("vm_exec_c1", 32'(exec), 32'd0);
    tick();
    sample();
    check("vm_req_c2", 32'(vmem_req), 32'd1);
    check("vm_exec_c2", 32'(exec), 32'd0);
    tick();
    vmem_ack = 1'b1;
    sample();
    check("vm_req_c3", 32'(vmem_req), 32'd1);
    check("vm_exec_ack", 32'(exec), 32'd1);
    tick();
    vmem_ack = 1'b0;
    sample();
    check("vm_req_drop", 32'(vmem_req), 32'd0);
    check("vm_addr7", 32'(addr), 32'd7);
    check("vm_run", 32'(state), 32'd1);

    // Framebuffer write with ack tied high.
    do_reset();
    rom[15] = {5'd9, 15'h0000};
    fb_ack  = 1'b1;
    enable  = 1'b1;
    tick();
    repeat (15) tick();
    sample();
    check("fb_addr15", 32'(addr), 32'd15);
    check("fb_exec_issue", 32'(exec), 32'd0);
    tick();
    sample();
    check("fb_req_c1", 32'(fb_req), 32'd1);
    check("fb_exec_ack", 32'(exec), 32'd1);
    tick();
    sample();
    check("fb_req_drop", 32'(fb_req), 32'd0);
    check("fb_addr16", 32'(addr), 32'd16);
    fb_ack = 1'b0;

    // Undefined opcode retires as gnop; ggoto ignores uop[14:8].
    do_reset();
    rom[1] = {5'd31, 15'h7FFF};
    rom[2] = {5'd12, 7'h7F, 8'h04};
    enable = 1'b1;
    tick();
    tick();
    sample();
    check("undef_exec", 32'(exec), 32'd1);
    tick();
    sample();
    check("goto_addr2", 32'(addr), 32'd2);
    tick();
    sample();
    check("goto_target", 32'(addr), 32'd4);

    // Disable during VRAM wait: retire on ack, then idle with PC rewound.
    do_reset();
    rom[6] = {5'd8, 15'h0000};
    enable = 1'b1;
    tick();
    repeat (7) tick();
    enable = 1'b0;
    sample();
    check("dis_wait", 32'(state), 32'd2);
    tick();
    tick();
    vmem_ack = 1'b1;
    sample();
    check("dis_state_ack", 32'(state), 32'd2);
    check("dis_exec_ack", 32'(exec), 32'd1);
    tick();
    vmem_ack = 1'b0;
    sample();
    check("dis_idle", 32'(state), 32'd0);
    check("dis_addr", 32'(addr), 32'd0);
    check("dis_req", 32'(vmem_req), 32'd0);
    check("dis_exec", 32'(exec), 32'd0);

    // Reset asserted in framebuffer wait, coincident with ack.
    do_reset();
    rom[15] = {5'd9, 15'h0000};
    enable  = 1'b1;
    tick();
    repeat (16) tick();
    sample();
    check("rfb_req", 32'(fb_req), 32'd1);
    check("rfb_state", 32'(state), 32'd3);
    tick();
    rst    = 1'b1;
    fb_ack = 1'b1;
    sample();
    check("rfb_exec_rst", 32'(exec), 32'd0);
    tick();
    sample();
    check("rfb_req_drop", 32'(fb_req), 32'd0);
    check("rfb_idle", 32'(state), 32'd0);
    check("rfb_addr", 32'(addr), 32'd0);
    check("rfb_exec", 32'(exec), 32'd0);
    rst    = 1'b0;
    fb_ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
